// File: rtl/capture_buf.sv
// capture_buf
//
// Sample-capture buffer fed by edge_det in the 4-channel logic analyzer.
// Once armed, it records channel samples into a circular RAM of DEPTH = 2^AW
// entries. It retains PRE samples ahead of the trigger and freezes the buffer
// DEPTH-PRE samples after it (the trigger sample is included in that count).
// The frozen capture is then streamed out oldest sample first.
//
// Optional feature macro: CAPTURE_DECIM_EN
//   When defined, an extra 8-bit 'div' input decimates the sample strobe to
//   one strobe every div+1 cycles. A 'we' pulse that arrives between strobes
//   is held until the next strobe.
//
// Parameters:
//   CH    channel count / sample width
//   AW    RAM address width, DEPTH = 2^AW
//   PRE   pre-trigger samples retained, 1..DEPTH-1
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low, clears all state
//   arm           single-cycle pulse starting a capture (honoured in IDLE/DONE)
//   data[CH]      channel samples
//   we            trigger level from edge_det
//   div[8]        strobe divider (CAPTURE_DECIM_EN only)
//   rd_req        request next captured sample
//   write_finish  capture complete, returned to edge_det
//   busy          high while filling, armed or post-triggering
//   rd_data[CH]   read sample
//   rd_valid      one-cycle strobe qualifying rd_data
//   rd_last       high with the final rd_valid of a capture
module capture_buf #(
  parameter int CH  = 4,
  parameter int AW  = 10,
  parameter int PRE = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [CH-1:0] data,
  input  logic          we,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]    div,
`endif
  input  logic          rd_req,
  output logic          write_finish,
  output logic          busy,
  output logic [CH-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] PRE_LAST   = (AW+1)'(PRE - 1);
  localparam logic [AW:0] POST_LAST  = (AW+1)'(DEPTH - PRE - 1);
  localparam logic [AW:0] DEPTH_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRE);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   trig_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   trig_base;
  logic [AW:0]     cnt;
  logic [AW:0]     rd_cnt;
  logic            mem_we;
  logic            rd_go;
  logic            arm_go;
  logic            strobe;
  logic            trig;
  logic [CH-1:0]   mem [DEPTH];

  assign arm_go = arm && (state == IDLE || state == DONE);

`ifdef CAPTURE_DECIM_EN
  logic [7:0] pre_cnt;
  logic       we_held;

  // The >= compare keeps the strobe alive if div shrinks below the running count.
  assign strobe = (pre_cnt >= div);
  assign trig   = we | we_held;

  // Prescaler restarts with each accepted arm. A trigger seen between strobes
  // is held so the next strobe still acts on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      we_held <= 1'b0;
    end else begin
      if (arm_go || strobe) pre_cnt <= '0;
      else                  pre_cnt <= pre_cnt + 8'd1;
      if (state != ARMED || strobe) we_held <= 1'b0;
      else if (we)                  we_held <= 1'b1;
    end
  end
`else
  assign strobe = 1'b1;
  assign trig   = we;
`endif

  // When the trigger itself completes the capture, trig_ptr is not yet loaded.
  assign trig_base = (state == ARMED) ? wr_ptr : trig_ptr;

  assign busy         = (state == FILL) || (state == ARMED) || (state == POST);
  assign write_finish = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    rd_go      = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_next = FILL;
      end
      FILL: begin
        if (strobe) begin
          mem_we = 1'b1;
          if (cnt == PRE_LAST) state_next = ARMED;
        end
      end
      ARMED: begin
        if (strobe) begin
          mem_we = 1'b1;
          if (trig) state_next = (POST_LAST == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (strobe) begin
          mem_we = 1'b1;
          if (cnt == POST_LAST) state_next = DONE;
        end
      end
      DONE: begin
        // A restarting arm wins over a read in the same cycle.
        if (arm) begin
          state_next = FILL;
        end else if (rd_req && !rd_valid) begin
          rd_go = 1'b1;
          if (rd_cnt == DEPTH_LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      trig_ptr <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      rd_last  <= rd_go && (rd_cnt == DEPTH_LAST);
      if (arm_go) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (mem_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (state == ARMED && trig) begin
          trig_ptr <= wr_ptr;
          cnt      <= (AW+1)'(1);
        end else if (state != ARMED) begin
          cnt <= cnt + 1'b1;
        end
      end
      // The oldest retained sample sits PRE entries behind the trigger.
      if (state != DONE && state_next == DONE) begin
        rd_ptr <= trig_base - PRE_OFS;
        rd_cnt <= '0;
      end else if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Sample storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_go) rd_data <= mem[rd_ptr];
  end

endmodule

// File: doc/capture_buf.md
# capture_buf

Sample-capture buffer directly downstream of `edge_det` in the 4-channel logic analyzer data path. Continuously records channel samples into a circular RAM once armed, retains a fixed pre-trigger window, and freezes the buffer after a fixed post-trigger count once `edge_det` raises `we`. It returns `write_finish` to `edge_det` and streams the frozen capture, oldest sample first, to the readout side.

## Interface
- `CH`, 4, channel count / sample width
- `AW`, 10, RAM address width; DEPTH = 2^AW samples
- `PRE`, 256, pre-trigger samples retained; legal range 1..DEPTH-1
- `clk` in 1, sole clock, all logic on rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `arm` in 1, single-cycle pulse that starts a capture
- `data` in CH, channel samples
- `we` in 1, trigger from `edge_det` (level; first high cycle in ARMED counts)
- `rd_req` in 1, request next captured sample
- `write_finish` out 1, capture complete, to `edge_det`
- `busy` out 1, high in FILL, ARMED, POST
- `rd_data` out CH, read sample
- `rd_valid` out 1, one-cycle strobe qualifying `rd_data`
- `rd_last` out 1, high with the final `rd_valid` of a capture

## Operation
- States: IDLE, FILL, ARMED, POST, DONE.
- IDLE: no writes. `arm` -> FILL; wr_ptr=0, cnt=0.
- FILL: write `data` at wr_ptr each sample strobe, wr_ptr++, cnt++; cnt reaching PRE -> ARMED. `we` ignored.
- ARMED: write each strobe, wr_ptr wraps mod DEPTH. `we`=1 on a strobe -> POST; that cycle's sample is the trigger sample, trig_ptr=wr_ptr, cnt=1.
- POST: write each strobe, cnt++; when cnt reaches DEPTH-PRE (trigger sample included) -> DONE; rd_ptr = (trig_ptr - PRE) mod DEPTH.
- DONE: `write_finish`=1. `rd_req` with no read in flight reads RAM[rd_ptr], rd_ptr++ mod DEPTH, rd_cnt++. `rd_req` during an in-flight read is ignored. After DEPTH reads: `rd_last` with last `rd_valid`, then -> IDLE.
- `arm` in DONE aborts readout and restarts (-> FILL). `arm` in FILL/ARMED/POST ignored.
- RAM: single write port, synchronous read port; inferrable as block RAM, no reset on contents.
- Pointer/counter arithmetic is AW bits, wrap by natural overflow; cnt/rd_cnt are AW+1 bits.

## Timing
- Reset (`reset`=0): state IDLE; `write_finish`, `busy`, `rd_valid`, `rd_last` = 0; `rd_data` = 0. Effective immediately, mid-operation included; capture discarded.
- Sample strobe: every cycle (see Configuration). `data` and `we` sampled on the same edge.
- `busy` rises the cycle after `arm`; `write_finish` rises the cycle after the last POST write and falls the cycle after the final read or a restarting `arm`.
- Read latency: `rd_valid` exactly 1 cycle after accepted `rd_req`; max throughput one sample per 2 cycles.
- Capture length: always exactly DEPTH samples: PRE before the trigger, trigger sample, DEPTH-PRE-1 after.

## Configuration
- `CAPTURE_DECIM_EN` defined: extra input `div` (8 bits); sample strobe fires once every div+1 cycles (div=0 -> every cycle), prescaler cleared on `arm`; `we` only acts on strobe cycles, and is latched between strobes so a one-cycle trigger is not lost.
- Undefined: no `div` port; strobe every cycle; no prescaler logic.

## Test plan
Use AW=4 (DEPTH=16), PRE=4, `data` = cycle counter mod 16.
- Hold `reset`=0 mid-POST -> all outputs 0 immediately; after release, state IDLE, `write_finish`=0 until a new capture completes.
- `arm`, `we` pulse 10 cycles after ARMED entry (trigger sample 0xE) -> `write_finish` after 12 post writes; 16 reads return 0xA,0xB,...,0x9 in order; `rd_last` on 16th.
- `we`=1 throughout FILL -> no trigger until first ARMED cycle; trigger sample = value at cycle 4 after arm (0x4 if counter starts 0 at arm).
- Trigger after 40 ARMED cycles (wr_ptr wrapped twice) -> readout still oldest-first, 4 pre-trigger values then trigger value, contiguous.
- `rd_req` held high continuously -> `rd_valid` every other cycle, exactly 16 strobes, then IDLE; `arm` after 5 reads -> readout aborted, `busy`=1 next cycle.
- With `CAPTURE_DECIM_EN`, div=2, one-cycle `we` between strobes -> samples written every 3rd cycle, trigger taken on next strobe, capture spans 48 cycles.
